// File: rtl/itof_pipe_if.sv
// itof_pipe_if: request/response valid-ready handshake for the integer-to-float converter.
interface itof_pipe_if;
    logic        in_valid, in_ready, in_unsigned;
    logic        out_valid, out_ready;
    logic [31:0] x, y;
    modport master (output in_valid, x, in_unsigned, out_ready, input in_ready, out_valid, y);
    modport slave (input in_valid, x, in_unsigned, out_ready, output in_ready, out_valid, y);
endinterface

// File: rtl/itof_pipe.sv
// itof_pipe: two-stage int32/uint32 to IEEE-754 single converter (fcvt.s.w / fcvt.s.wu).
// Stage 1 takes magnitude and leading-zero count; stage 2 normalizes, rounds and packs.
module itof_pipe #(
    parameter bit TIE_EVEN = 1'b1
) (
    input logic        clk,
    input logic        rstn,
    itof_pipe_if.slave io
);
    logic        s1_valid_q, s1_valid_d, s1_sign_q, s1_sign_d, s2_valid_q, s2_valid_d;
    logic [31:0] s1_mag_q, s1_mag_d, y_q, y_d;
    logic [5:0]  s1_lz_q, s1_lz_d;
    logic        s1_adv, s2_adv, sign, rup, carry;
    logic [31:0] mag, packed_y;
    logic [30:0] norm;
    logic [5:0]  lz;
    logic [22:0] frac;
    logic [7:0]  exp_v;
    always_comb begin
        s2_adv = !s2_valid_q || io.out_ready;
        s1_adv = !s1_valid_q || s2_adv;
        sign = !io.in_unsigned && io.x[31];
        mag = sign ? ~io.x + 32'd1 : io.x;
        lz = 6'd32;
        for (int i = 0; i < 32; i++) if (mag[i]) lz = 6'(31 - i);
        norm = 31'(s1_mag_q << s1_lz_q[4:0]);
        rup = norm[7] && (TIE_EVEN ? (|norm[6:0] || norm[8]) : 1'b1);
        {carry, frac} = {1'b0, norm[30:8]} + 24'(rup);
        exp_v = 8'd158 - {2'b0, s1_lz_q} + {7'b0, carry};
        // lz of 32 only occurs for a zero magnitude, which must pack as +0
        packed_y = s1_lz_q[5] ? 32'd0 : {s1_sign_q, exp_v, frac};
        s1_valid_d = s1_adv ? io.in_valid : s1_valid_q;
        s1_sign_d = s1_adv && io.in_valid ? sign : s1_sign_q;
        s1_mag_d = s1_adv && io.in_valid ? mag : s1_mag_q;
        s1_lz_d = s1_adv && io.in_valid ? lz : s1_lz_q;
        s2_valid_d = s2_adv ? s1_valid_q : s2_valid_q;
        y_d = s2_adv && s1_valid_q ? packed_y : y_q;
    end
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            s1_valid_q <= 1'b0;
            s1_sign_q <= 1'b0;
            s1_mag_q <= 32'd0;
            s1_lz_q <= 6'd0;
            s2_valid_q <= 1'b0;
            y_q <= 32'd0;
        end else begin
            s1_valid_q <= s1_valid_d;
            s1_sign_q <= s1_sign_d;
            s1_mag_q <= s1_mag_d;
            s1_lz_q <= s1_lz_d;
            s2_valid_q <= s2_valid_d;
            y_q <= y_d;
        end
    end
    assign io.in_ready = s1_adv;
    assign io.out_valid = s2_valid_q;
    assign io.y = y_q;
endmodule

// File: tb/tb_itof_pipe.sv
// tb_itof_pipe: vector table, backpressure, random stream and async reset checks
// for both tie rules, with a scoreboard of expected results in acceptance order.
module tb_itof_pipe;
    logic clk = 1'b0;
    logic rstn = 1'b0;
    itof_pipe_if io0 ();
    itof_pipe_if io1 ();
    itof_pipe #(.TIE_EVEN(1'b1)) dut0 (.clk(clk), .rstn(rstn), .io(io0.slave));
    itof_pipe #(.TIE_EVEN(1'b0)) dut1 (.clk(clk), .rstn(rstn), .io(io1.slave));
    assign io1.in_valid = io0.in_valid;
    assign io1.x = io0.x;
    assign io1.in_unsigned = io0.in_unsigned;
    assign io1.out_ready = io0.out_ready;
    always #5 clk = ~clk;

    typedef struct {logic [31:0] x; bit uns; logic [31:0] y1, y0;} vec_t;
    typedef struct {logic [31:0] y1, y0; int cyc;} sb_t;
    sb_t sb[$];
    int n_chk = 0, n_fail = 0, cyc = 0, n;
    bit chk_lat, acc;
    logic [31:0] e1_in, e0_in;
    vec_t tv[13];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", nm, act, want, cyc);
        end
    endtask

    // Independent reference: find MSB, shift down, round on the discarded remainder.
    function automatic logic [31:0] ref_cvt(input logic [31:0] xv, input bit uns, input bit te);
        logic s;
        logic [63:0] m, k, r, h;
        int p, e, sh;
        s = !uns && xv[31];
        m = s ? 64'h1_0000_0000 - {32'd0, xv} : {32'd0, xv};
        if (m == 0) return 32'd0;
        p = 0;
        for (int i = 0; i < 32; i++) if (m[i]) p = i;
        e = 127 + p;
        if (p <= 23) k = m << (23 - p);
        else begin
            sh = p - 23;
            k = m >> sh;
            r = m & ((64'd1 << sh) - 1);
            h = 64'd1 << (sh - 1);
            if (r > h || (r == h && (!te || k[0]))) k = k + 1;
            if (k == (64'd1 << 24)) begin
                k = k >> 1;
                e++;
            end
        end
        return {s, e[7:0], k[22:0]};
    endfunction

    task automatic cycle();
        sb_t e;
        #1;
        if (io0.out_valid && io0.out_ready) begin
            if (sb.size() == 0) check("unexpected_output", io0.y, 32'hxxxxxxxx);
            else begin
                e = sb.pop_front();
                check("y_tie_even", io0.y, e.y1);
                check("y_tie_away", io1.y, e.y0);
                if (chk_lat) check("latency", 32'(cyc - e.cyc), 32'd2);
            end
        end
        acc = io0.in_valid && io0.in_ready;
        if (acc) sb.push_back('{e1_in, e0_in, cyc});
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    task automatic set_model(input logic [31:0] xv, input bit uns);
        io0.x = xv;
        io0.in_unsigned = uns;
        e1_in = ref_cvt(xv, uns, 1'b1);
        e0_in = ref_cvt(xv, uns, 1'b0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        tv = '{'{32'd1, 1'b0, 32'h3F800000, 32'h3F800000},
               '{32'd3, 1'b0, 32'h40400000, 32'h40400000},
               '{32'hFFFFFFFF, 1'b0, 32'hBF800000, 32'hBF800000},
               '{32'd0, 1'b0, 32'h00000000, 32'h00000000},
               '{32'h7FFFFFFF, 1'b0, 32'h4F000000, 32'h4F000000},
               '{32'h80000000, 1'b0, 32'hCF000000, 32'hCF000000},
               '{32'hFFFFFFFF, 1'b1, 32'h4F800000, 32'h4F800000},
               '{32'h80000000, 1'b1, 32'h4F000000, 32'h4F000000},
               '{32'd16777217, 1'b0, 32'h4B800000, 32'h4B800001},
               '{32'd16777219, 1'b0, 32'h4B800002, 32'h4B800002},
               '{32'd16777218, 1'b0, 32'h4B800001, 32'h4B800001},
               '{32'd16777221, 1'b0, 32'h4B800002, 32'h4B800003},
               '{32'hFEFFFFFF, 1'b0, 32'hCB800000, 32'hCB800001}};
        io0.in_valid = 1'b0;
        io0.x = 32'd0;
        io0.in_unsigned = 1'b0;
        io0.out_ready = 1'b1;
        chk_lat = 1'b1;
        #1;
        check("reset_out_valid", 32'(io0.out_valid), 32'd0);
        check("reset_y", io0.y, 32'd0);
        check("reset_y_away", io1.y, 32'd0);
        check("reset_in_ready", 32'(io0.in_ready), 32'd1);
        @(negedge clk);
        @(negedge clk);
        rstn = 1'b1;
        @(negedge clk);

        foreach (tv[i]) begin
            io0.in_valid = 1'b1;
            io0.x = tv[i].x;
            io0.in_unsigned = tv[i].uns;
            e1_in = tv[i].y1;
            e0_in = tv[i].y0;
            cycle();
            io0.in_valid = 1'b0;
            for (int c = 0; c < 4; c++) cycle();
        end
        check("table_drained", 32'(sb.size()), 32'd0);

        chk_lat = 1'b0;
        n = 0;
        for (int c = 0; c < 20; c++) begin
            io0.out_ready = c >= 4;
            io0.in_valid = n < 5;
            set_model(32'(n + 1), 1'b0);
            if (c == 2) check("bp_in_ready_low", 32'(io0.in_ready), 32'd0);
            if (c == 2 || c == 3) begin
                check("bp_out_valid_held", 32'(io0.out_valid), 32'd1);
                check("bp_y_stable", io0.y, 32'h3F800000);
            end
            cycle();
            if (acc) n++;
        end
        io0.in_valid = 1'b0;
        check("bp_accepted", 32'(n), 32'd5);
        check("bp_drained", 32'(sb.size()), 32'd0);

        n = 0;
        for (int c = 0; c < 3000 && (n < 100 || sb.size() != 0); c++) begin
            io0.in_valid = n < 100 && $urandom_range(0, 3) != 0;
            set_model($urandom_range(0, 3) == 0 ? 32'h01000000 | 32'($urandom_range(0, 15)) << $urandom_range(0, 7)
                                                : $urandom, 1'($urandom_range(0, 1)));
            io0.out_ready = $urandom_range(0, 2) != 0;
            cycle();
            if (acc) n++;
        end
        io0.in_valid = 1'b0;
        io0.out_ready = 1'b1;
        check("rand_accepted", 32'(n), 32'd100);
        check("rand_drained", 32'(sb.size()), 32'd0);

        io0.out_ready = 1'b0;
        io0.in_valid = 1'b1;
        set_model(32'd7, 1'b0);
        cycle();
        set_model(32'd9, 1'b0);
        cycle();
        io0.in_valid = 1'b0;
        #2 rstn = 1'b0;
        #1;
        check("rst_out_valid", 32'(io0.out_valid), 32'd0);
        check("rst_y", io0.y, 32'd0);
        check("rst_y_away", io1.y, 32'd0);
        sb.delete();
        #1 rstn = 1'b1;
        @(negedge clk);
        io0.out_ready = 1'b1;
        for (int c = 0; c < 3; c++) begin
            cycle();
            check("rst_no_stale", 32'(io0.out_valid), 32'd0);
        end
        chk_lat = 1'b1;
        io0.in_valid = 1'b1;
        set_model(32'd5, 1'b0);
        e1_in = 32'h40A00000;
        e0_in = 32'h40A00000;
        cycle();
        io0.in_valid = 1'b0;
        for (int c = 0; c < 4; c++) cycle();
        check("rst_new_drained", 32'(sb.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
